// File: rtl/noc_switch_allocator_pkg.sv
// rtl/noc_switch_allocator_pkg.sv - shared port indices, direction encodings and allocator state type
//
// Package noc: port count, port indices (N,S,W,E,L), one-hot direction_t
// encodings, the per-output allocator state enum and a cyclic port-step helper.
package noc;

    localparam int kPorts = 5;

    typedef logic [2:0] port_idx_t;

    localparam port_idx_t kNorthPort = 3'd0;
    localparam port_idx_t kSouthPort = 3'd1;
    localparam port_idx_t kWestPort  = 3'd2;
    localparam port_idx_t kEastPort  = 3'd3;
    localparam port_idx_t kLocalPort = 3'd4;

    typedef logic [kPorts-1:0] direction_t;

    localparam direction_t goNorth = 5'b00001;
    localparam direction_t goSouth = 5'b00010;
    localparam direction_t goWest  = 5'b00100;
    localparam direction_t goEast  = 5'b01000;
    localparam direction_t goLocal = 5'b10000;

    typedef enum logic {
        kIdle,
        kLocked
    } alloc_state_t;

    // Cyclic successor in the order N,S,W,E,L,N,...
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == kLocalPort) ? kNorthPort : port_idx_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/noc_switch_allocator_arbiter.sv
// rtl/noc_switch_allocator_arbiter.sv - per-output round-robin arbiter with wormhole lock and credit counter
//
// Module noc_output_arbiter, one instance per output port.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   req[i]        input i has a legal, unmasked request for this output
//   head[i]       flit at input i is a head flit
//   tail[i]       flit at input i is a tail flit
//   credit        downstream freed one slot this cycle
//   grant[i]      one-hot: input i transfers through this output this cycle
//   stall_cnt     (only with NOC_ALLOC_PERF_CNT_EN) saturating count of
//                 cycles with an eligible request but no credit
module noc_output_arbiter
    import noc::*;
#(
    parameter int DEPTH    = 4,
    parameter int CREDIT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [kPorts-1:0] req,
    input  logic [kPorts-1:0] head,
    input  logic [kPorts-1:0] tail,
    input  logic              credit,
    output logic [kPorts-1:0] grant
`ifdef NOC_ALLOC_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [CREDIT_W-1:0] kFull = CREDIT_W'(DEPTH);

    alloc_state_t        state, state_next;
    port_idx_t           owner, owner_next;
    port_idx_t           rr_ptr, rr_ptr_next;
    port_idx_t           winner;
    logic [CREDIT_W-1:0] credits, credits_next;
    logic [kPorts-1:0]   cand;
    logic                found;
    logic                has_credit;
    logic                transfer;

    assign has_credit = (credits != '0);
    assign cand       = req & head;

    // Search starts one past the last winner so the previous winner is
    // considered last.
    always_comb begin
        port_idx_t idx;
        found  = 1'b0;
        winner = rr_ptr;
        idx    = next_port(rr_ptr);
        for (int k = 0; k < kPorts; k++) begin
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = next_port(idx);
        end
    end

    // Grant is gated by rst so all outputs read 0 the moment reset asserts.
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        grant       = '0;
        if (rst) begin
            case (state)
                kIdle: begin
                    if (found && has_credit) begin
                        grant[winner] = 1'b1;
                        rr_ptr_next   = winner;
                        if (!tail[winner]) begin
                            state_next = kLocked;
                            owner_next = winner;
                        end
                    end
                end
                kLocked: begin
                    // Owner bubbles simply produce no grant; the lock holds.
                    if (req[owner] && has_credit) begin
                        grant[owner] = 1'b1;
                        if (tail[owner]) begin
                            state_next = kIdle;
                        end
                    end
                end
                default: state_next = kIdle;
            endcase
        end
    end

    assign transfer = |grant;

    // A credit returned while empty only becomes usable next cycle because
    // has_credit looks at the registered count.
    always_comb begin
        credits_next = credits;
        if (credit && !transfer) begin
            credits_next = (credits == kFull) ? credits : credits + 1'b1;
        end else if (!credit && transfer) begin
            credits_next = credits - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= kIdle;
            owner   <= kLocalPort;
            rr_ptr  <= kLocalPort;
            credits <= kFull;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            rr_ptr  <= rr_ptr_next;
            credits <= credits_next;
        end
    end

`ifdef NOC_ALLOC_PERF_CNT_EN
    logic eligible;

    assign eligible = (state == kIdle) ? (|cand) : req[owner];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (eligible && !has_credit && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    a_credit_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(credit && credits == kFull));
    a_credit_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(transfer && credits == '0));

endmodule

// File: rtl/noc_switch_allocator.sv
// rtl/noc_switch_allocator.sv - 5-port wormhole switch allocator with round-robin and credit flow control
//
// Top noc_switch_allocator. Optional macro: NOC_ALLOC_PERF_CNT_EN adds stall_cnt_out.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   req_valid_in     input i has a flit at its buffer head
//   req_routing_in   one-hot output requested by input i
//   req_head_in      head flag of input i's flit
//   req_tail_in      tail flag of input i's flit
//   credit_in        downstream of output o freed one slot
//   in_grant_out     input i pops this cycle
//   out_sel_out      one-hot crossbar select per output
//   out_valid_out    output o carries a flit this cycle
//   stall_cnt_out    (optional) per-output credit-stall cycle counters
module noc_switch_allocator
    import noc::*;
#(
    parameter int DEPTH    = 4,
    parameter int CREDIT_W = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic       [kPorts-1:0]       req_valid_in,
    input  direction_t [kPorts-1:0]       req_routing_in,
    input  logic       [kPorts-1:0]       req_head_in,
    input  logic       [kPorts-1:0]       req_tail_in,
    input  logic       [kPorts-1:0]       credit_in,
    output logic       [kPorts-1:0]       in_grant_out,
    output logic [kPorts-1:0][kPorts-1:0] out_sel_out,
    output logic       [kPorts-1:0]       out_valid_out
`ifdef NOC_ALLOC_PERF_CNT_EN
    ,
    output logic [kPorts-1:0][15:0]       stall_cnt_out
`endif
);

    logic [kPorts-1:0]             legal;
    logic [kPorts-1:0][kPorts-1:0] out_req;   // [output][input]
    logic [kPorts-1:0][kPorts-1:0] in_sel;    // [input][output]

    // Malformed (non one-hot) routing and U-turns never reach an arbiter.
    always_comb begin
        legal   = '0;
        out_req = '0;
        for (int i = 0; i < kPorts; i++) begin
            legal[i] = req_valid_in[i] && $onehot(req_routing_in[i]);
        end
        for (int o = 0; o < kPorts; o++) begin
            for (int i = 0; i < kPorts; i++) begin
                out_req[o][i] = legal[i] && req_routing_in[i][o] && (i != o);
            end
        end
    end

    for (genvar o = 0; o < kPorts; o++) begin : g_out
        noc_output_arbiter #(
            .DEPTH    (DEPTH),
            .CREDIT_W (CREDIT_W)
        ) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (out_req[o]),
            .head      (req_head_in),
            .tail      (req_tail_in),
            .credit    (credit_in[o]),
            .grant     (out_sel_out[o])
`ifdef NOC_ALLOC_PERF_CNT_EN
            ,
            .stall_cnt (stall_cnt_out[o])
`endif
        );

        assign out_valid_out[o] = |out_sel_out[o];

        a_sel_onehot: assert property (@(posedge clk) disable iff (!rst)
            $onehot0(out_sel_out[o]));
    end

    always_comb begin
        in_sel       = '0;
        in_grant_out = '0;
        for (int o = 0; o < kPorts; o++) begin
            for (int i = 0; i < kPorts; i++) begin
                in_sel[i][o] = out_sel_out[o][i];
            end
        end
        for (int i = 0; i < kPorts; i++) begin
            in_grant_out[i] = |in_sel[i];
        end
    end

    for (genvar i = 0; i < kPorts; i++) begin : g_in
        a_single_grant: assert property (@(posedge clk) disable iff (!rst)
            $onehot0(in_sel[i]));
    end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// tb/tb_noc_switch_allocator.sv - scoreboard testbench for noc_switch_allocator
module tb_noc_switch_allocator;
    import noc::*;

    localparam int N = 0;
    localparam int S = 1;
    localparam int W = 2;
    localparam int E = 3;
    localparam int L = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [4:0]             req_valid_in;
    direction_t [4:0]       req_routing_in;
    logic [4:0]             req_head_in;
    logic [4:0]             req_tail_in;
    logic [4:0]             credit_in;
    logic [4:0]             in_grant_out;
    logic [4:0][4:0]        out_sel_out;
    logic [4:0]             out_valid_out;
`ifdef NOC_ALLOC_PERF_CNT_EN
    logic [4:0][15:0]       stall_cnt_out;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [4:0]  grant;
        logic [4:0]  valid;
        logic [24:0] sel;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    noc_switch_allocator #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_in   (req_valid_in),
        .req_routing_in (req_routing_in),
        .req_head_in    (req_head_in),
        .req_tail_in    (req_tail_in),
        .credit_in      (credit_in),
        .in_grant_out   (in_grant_out),
        .out_sel_out    (out_sel_out),
        .out_valid_out  (out_valid_out)
`ifdef NOC_ALLOC_PERF_CNT_EN
        ,
        .stall_cnt_out  (stall_cnt_out)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t none();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t xfer(int o, int i);
        exp_t e;
        e = '0;
        e.grant[i]     = 1'b1;
        e.valid[o]     = 1'b1;
        e.sel[o*5 + i] = 1'b1;
        return e;
    endfunction

    task automatic clear_inputs();
        req_valid_in   = '0;
        req_routing_in = '0;
        req_head_in    = '0;
        req_tail_in    = '0;
        credit_in      = '0;
    endtask

    task automatic set_req(int i, int o, logic head, logic tail);
        req_valid_in[i]   = 1'b1;
        req_routing_in[i] = direction_t'(5'b00001 << o);
        req_head_in[i]    = head;
        req_tail_in[i]    = tail;
    endtask

    task automatic drop_req(int i);
        req_valid_in[i] = 1'b0;
        req_head_in[i]  = 1'b0;
        req_tail_in[i]  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        clear_inputs();
        #2;
        set_req(E, N, 1'b1, 1'b1);
        set_req(S, E, 1'b1, 1'b0);
        sb.push_back(none());
        #2;
        e = sb.pop_front();
        tests_run++;
        if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required %h", {in_grant_out, out_valid_out, out_sel_out}, e);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b1;
        sb.push_back(none());
        #4;
        e = sb.pop_front();
        tests_run++;
        if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
            tests_failed++;
            $display("FAIL reset_idle: got %h required %h", {in_grant_out, out_valid_out, out_sel_out}, e);
        end
        @(posedge clk);
        #1;
    endtask

    // E and L flood North; round robin from L gives E first, credits run out after 4.
    task automatic test_credit_alternation();
        exp_t e;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            set_req(E, N, 1'b1, 1'b1);
            set_req(L, N, 1'b1, 1'b1);
            credit_in = '0;
            case (c)
                0, 2:    sb.push_back(xfer(N, E));
                1, 3:    sb.push_back(xfer(N, L));
                6: begin
                    credit_in[N] = 1'b1;
                    sb.push_back(none());
                end
                7:       sb.push_back(xfer(N, E));
                default: sb.push_back(none());
            endcase
            #4;
            e = sb.pop_front();
            tests_run++;
            if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
                tests_failed++;
                $display("FAIL alternation c%0d: got %h required %h", c, {in_grant_out, out_valid_out, out_sel_out}, e);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    // W holds East for a 3-flit packet with a bubble; N waits until after the tail.
    task automatic test_wormhole_lock();
        exp_t e;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin
                    set_req(W, E, 1'b1, 1'b0);
                    sb.push_back(xfer(E, W));
                end
                1: begin
                    drop_req(W);
                    set_req(N, E, 1'b1, 1'b1);
                    sb.push_back(none());
                end
                2: begin
                    set_req(W, E, 1'b0, 1'b0);
                    sb.push_back(xfer(E, W));
                end
                3: begin
                    set_req(W, E, 1'b0, 1'b1);
                    sb.push_back(xfer(E, W));
                end
                4: begin
                    drop_req(W);
                    sb.push_back(xfer(E, N));
                end
                default: begin
                    clear_inputs();
                    sb.push_back(none());
                end
            endcase
            #4;
            e = sb.pop_front();
            tests_run++;
            if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
                tests_failed++;
                $display("FAIL wormhole c%0d: got %h required %h", c, {in_grant_out, out_valid_out, out_sel_out}, e);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    task automatic test_uturn_mask();
        exp_t e;
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            set_req(N, N, 1'b1, 1'b1);
            if (c == 0) begin
                set_req(S, N, 1'b1, 1'b1);
                sb.push_back(xfer(N, S));
            end else begin
                drop_req(S);
                sb.push_back(none());
            end
            #4;
            e = sb.pop_front();
            tests_run++;
            if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
                tests_failed++;
                $display("FAIL uturn c%0d: got %h required %h", c, {in_grant_out, out_valid_out, out_sel_out}, e);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    // Drain South, then a credit returned at zero is usable only next cycle,
    // where it coincides with a transfer and nets to zero.
    task automatic test_credit_return();
        exp_t e;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            set_req(N, S, 1'b1, 1'b1);
            credit_in = '0;
            case (c)
                0, 1, 2, 3: sb.push_back(xfer(S, N));
                4: begin
                    credit_in[S] = 1'b1;
                    sb.push_back(none());
                end
                5: begin
                    credit_in[S] = 1'b1;
                    sb.push_back(xfer(S, N));
                end
                6:       sb.push_back(xfer(S, N));
                default: sb.push_back(none());
            endcase
            #4;
            e = sb.pop_front();
            tests_run++;
            if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
                tests_failed++;
                $display("FAIL credit_return c%0d: got %h required %h", c, {in_grant_out, out_valid_out, out_sel_out}, e);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_packet();
        exp_t e;
        apply_reset();
        for (int c = 0; c < 2; c++) begin
            set_req(W, E, (c == 0), 1'b0);
            sb.push_back(xfer(E, W));
            #4;
            e = sb.pop_front();
            tests_run++;
            if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
                tests_failed++;
                $display("FAIL midpkt_pre c%0d: got %h required %h", c, {in_grant_out, out_valid_out, out_sel_out}, e);
            end
            if (c == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b0;
        sb.push_back(none());
        #1;
        e = sb.pop_front();
        tests_run++;
        if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
            tests_failed++;
            $display("FAIL midpkt_async: got %h required %h", {in_grant_out, out_valid_out, out_sel_out}, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Body flit to an idle output is ignored; then 4 credits must be back.
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin
                set_req(W, E, 1'b0, 1'b0);
                sb.push_back(none());
            end else begin
                set_req(W, E, 1'b1, 1'b1);
                sb.push_back((c <= 4) ? xfer(E, W) : none());
            end
            #4;
            e = sb.pop_front();
            tests_run++;
            if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
                tests_failed++;
                $display("FAIL midpkt_post c%0d: got %h required %h", c, {in_grant_out, out_valid_out, out_sel_out}, e);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

`ifdef NOC_ALLOC_PERF_CNT_EN
    task automatic test_perf_counter();
        exp_t e;
        apply_reset();
        tests_run++;
        if (stall_cnt_out !== '0) begin
            tests_failed++;
            $display("FAIL perf_reset: got %h required 0", stall_cnt_out);
        end
        for (int c = 0; c < 14; c++) begin
            set_req(N, S, 1'b1, 1'b1);
            sb.push_back((c < 4) ? xfer(S, N) : none());
            #4;
            e = sb.pop_front();
            tests_run++;
            if ({in_grant_out, out_valid_out, out_sel_out} !== e) begin
                tests_failed++;
                $display("FAIL perf_grant c%0d: got %h required %h", c, {in_grant_out, out_valid_out, out_sel_out}, e);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
        #2;
        tests_run++;
        if (stall_cnt_out[S] !== 16'd10) begin
            tests_failed++;
            $display("FAIL perf_count_s: got %0d required 10", stall_cnt_out[S]);
        end
        tests_run++;
        if ({stall_cnt_out[N], stall_cnt_out[W], stall_cnt_out[E], stall_cnt_out[L]} !== 64'd0) begin
            tests_failed++;
            $display("FAIL perf_count_other: got %h required 0", stall_cnt_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_credit_alternation();
        test_wormhole_lock();
        test_uturn_mask();
        test_credit_return();
        test_reset_mid_packet();
`ifdef NOC_ALLOC_PERF_CNT_EN
        test_perf_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/noc_switch_allocator.md
Name: noc_switch_allocator

Overview:
- Per-router switch allocator for the 5-port 2D-mesh wormhole router with lookahead YX routing.
- Each input's head flit carries a one-hot routing request (noc::direction_t) already computed one hop earlier.
- The block arbitrates every output port round-robin among the requesting inputs and locks the output to the winner until its tail flit transfers.
- It tracks downstream buffer credits per output and issues grants only when at least one credit is available.

Parameters:
- DEPTH, 4, downstream input-buffer depth in flits; the credit counters reset to this value.
- CREDIT_W, $clog2(DEPTH+1), credit counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid_in  in  [noc::kPorts]  input i has a flit at its buffer head.
- req_routing_in  in  [noc::kPorts] x noc::direction_t  one-hot output requested by input i.
- req_head_in  in  [noc::kPorts]  flit at input i is a head flit.
- req_tail_in  in  [noc::kPorts]  flit at input i is a tail flit (head+tail = single-flit packet).
- credit_in  in  [noc::kPorts]  downstream of output o freed one slot this cycle.
- in_grant_out  out  [noc::kPorts]  flit at input i transfers this cycle (pop).
- out_sel_out  out  [noc::kPorts] x [noc::kPorts]  one-hot input driving output o (crossbar select).
- out_valid_out  out  [noc::kPorts]  output o carries a flit this cycle.

Behaviour:
- Grants are combinational from the current inputs and the registered state, with zero-cycle latency. All state updates on posedge clk.
- On reset (rst=0), asynchronously:
  - every output is IDLE;
  - rr_ptr[o]=kLocalPort;
  - credits[o]=DEPTH;
  - the outputs above evaluate to 0.
- Legal request: req_valid_in[i] and req_routing_in[i] is one-hot. A request from i to o where i==o (U-turn or local loopback) is masked and never granted.
- Per output o, the FSM is IDLE or LOCKED(owner).
- IDLE:
  - Candidates are inputs with a legal request for o and req_head_in set.
  - If candidates exist and credits[o]>0, grant the first candidate strictly after rr_ptr[o] in cyclic order N,S,W,E,L. Assert in_grant_out, out_sel_out and out_valid_out, and set rr_ptr[o] to the winner.
  - If the granted flit is not a tail, go to LOCKED(winner); otherwise stay IDLE.
  - A non-head flit requesting an IDLE output is ignored.
- LOCKED(owner):
  - Only the owner is eligible. A transfer happens when the owner has a legal request for o and credits[o]>0.
  - A transfer whose flit has req_tail_in set returns the output to IDLE.
  - Owner bubbles (valid=0) hold the lock. Other inputs stall.
- Credit counters:
  - next = credits + credit_in[o] − transfer[o]; a simultaneous credit_in and transfer nets to 0.
  - credits=0 blocks grants even when credit_in is high that cycle; the returned credit is usable next cycle.
  - credit_in at credits==DEPTH is a protocol error. The counter saturates at DEPTH and an assertion fires.
- Invariants:
  - each input is granted by at most one output;
  - out_sel_out[o] is $onehot0;
  - credits never underflow.
- A reset during a locked packet drops the lock immediately. Upstream buffers are reset by the same rst.

Optional Feature:
- Macro: NOC_ALLOC_PERF_CNT_EN.
- When defined:
  - adds output port stall_cnt_out [noc::kPorts] x 16;
  - per output, a saturating count of cycles with an eligible request but credits==0;
  - cleared by rst.
- When undefined, the port and counters are absent. Allocation behaviour is identical either way.

Decomposition:
- Package noc holds:
  - kPorts=5;
  - port indices kNorthPort=0, kSouthPort=1, kWestPort=2, kEastPort=3, kLocalPort=4;
  - direction_t and goNorth/goSouth/goWest/goEast/goLocal;
  - a new alloc_state_t enum {kIdle, kLocked}.
- Sub-module noc_output_arbiter, instantiated once per output port. It owns the FSM, rr_ptr, the credit counter and the optional stall counter. The top handles request masking, per-output request vectors and transposing grants to in_grant_out.

Test Plan:
- After reset, E and L each send single-flit head+tail packets to goNorth every cycle with DEPTH credits → N grants alternate E,L,E,L and credits[N] goes 4→0. Grants then stop until credit_in[N] arrives and resume one cycle after it.
- W sends a 3-flit packet to goEast while N requests goEast with a head in cycle 1 → E is locked to W for 3 transfers including a bubble cycle. N is granted in the cycle after W's tail.
- Input N requests goNorth (U-turn) → never granted, out_valid_out[N]=0. A concurrent legal S→N request is granted.
- Credits[S]=0 with credit_in[S]=1 and an eligible request → no grant that cycle, grant next cycle. The counter nets correctly under simultaneous credit and transfer.
- Assert rst mid-packet while out_valid_out[E]=1 → outputs 0 immediately, credits=DEPTH. A non-head flit to E after reset is ignored.
- With NOC_ALLOC_PERF_CNT_EN defined, hold an eligible request with 0 credits for 10 cycles → stall_cnt_out for that output = 10.
